// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the boot-time instruction memory loader.
package imem_loader_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA
    } state_t;

    // Byte lane of the next data byte; byte_size is a power of two.
    function automatic logic [LEN_W-1:0] lane_of(input logic [LEN_W-1:0] cnt,
                                                 input int unsigned      byte_size);
        return cnt % LEN_W'(byte_size);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in (valid/ready) and word write port out of the loader.
interface imem_loader_if #(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 12
);
    logic                    s_valid;
    logic [7:0]              s_data;
    logic                    s_ready;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [8*BYTE_SIZE-1:0]  wr_data;
    logic [BYTE_SIZE-1:0]    wr_be;

    // master: stream source / memory side; slave: the loader itself
    modport master (
        output s_valid, s_data,
        input  s_ready, wr_en, wr_addr, wr_data, wr_be
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, wr_en, wr_addr, wr_data, wr_be
    );

endinterface

// File: rtl/imem_word_packer.sv
// Packs bytes little-endian into one word and emits a registered write on flush.
module imem_word_packer #(
    parameter int BYTE_SIZE = 4,
    parameter int LANE_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   load,
    input  logic                   flush,
    input  logic [7:0]             byte_in,
    input  logic [LANE_W-1:0]      lane,
    output logic [8*BYTE_SIZE-1:0] word,
    output logic [BYTE_SIZE-1:0]   be,
    output logic                   strobe
);

    logic [8*BYTE_SIZE-1:0] acc_data;
    logic [BYTE_SIZE-1:0]   acc_be;
    logic [8*BYTE_SIZE-1:0] merged_data;
    logic [BYTE_SIZE-1:0]   merged_be;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        merged_data               = acc_data;
        merged_be                 = acc_be;
        merged_data[lane*8 +: 8]  = byte_in;
        merged_be[lane]           = 1'b1;
    end

    // NOTE: the accumulator is a handful of flops, not a RAM array, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data <= '0;
            acc_be   <= '0;
            word     <= '0;
            be       <= '0;
            strobe   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            strobe <= 1'b0;
            if (clear) begin
                acc_data <= '0;
                acc_be   <= '0;
            end else if (load) begin
                if (flush) begin
                    word     <= merged_data;
                    be       <= merged_be;
                    strobe   <= 1'b1;
                    acc_data <= '0;
                    acc_be   <= '0;
                end else begin
                    acc_data <= merged_data;
                    acc_be   <= merged_be;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte stream loader into the instruction memory; holds the core while loading.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_BYTES  = 56
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         busy,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);

    localparam int LANE_W = (BYTE_SIZE > 1) ? $clog2(BYTE_SIZE) : 1;

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      cnt_q;
    logic [LEN_W-1:0]      len_q;
    logic [7:0]            len_lo_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  done_q, err_q;

    logic                  fire, clear, load, flush, set_done, set_err, last_byte;
    logic [LEN_W-1:0]      len_rx;
    logic [LANE_W-1:0]     lane;

    assign bus.s_ready = (state_q != IDLE);
    assign fire        = bus.s_valid && bus.s_ready;
    assign len_rx      = {bus.s_data, len_lo_q};
    assign last_byte   = ((cnt_q + LEN_W'(1)) == len_q);
    assign lane        = LANE_W'(lane_of(cnt_q, BYTE_SIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        load     = 1'b0;
        flush    = 1'b0;
        set_done = 1'b0;
        set_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (fire) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (fire) begin
                    if (len_rx == '0) begin
                        set_done = 1'b1;
                        state_d  = IDLE;
                    end else if (len_rx > LEN_W'(MEM_BYTES)) begin
                        set_err = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (fire) begin
                    load  = 1'b1;
                    flush = last_byte || (lane == LANE_W'(BYTE_SIZE - 1));
                    if (last_byte) begin
                        set_done = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            len_q     <= '0;
            len_lo_q  <= '0;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (clear) begin
                cnt_q  <= '0;
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (state_q == LEN_LO && fire) len_lo_q <= bus.s_data;
            if (state_q == LEN_HI && fire) len_q    <= len_rx;
            if (load)                      cnt_q    <= cnt_q + LEN_W'(1);
            // Word address of the flushing byte: counter with lane bits cleared.
            if (flush) wr_addr_q <= ADDR_WIDTH'(cnt_q) & ~ADDR_WIDTH'(BYTE_SIZE - 1);
            if (set_done) done_q <= 1'b1;
            if (set_err)  err_q  <= 1'b1;
        end
    end

    imem_word_packer #(
        .BYTE_SIZE (BYTE_SIZE),
        .LANE_W    (LANE_W)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .load    (load),
        .flush   (flush),
        .byte_in (bus.s_data),
        .lane    (lane),
        .word    (bus.wr_data),
        .be      (bus.wr_be),
        .strobe  (bus.wr_en)
    );

    assign bus.wr_addr = wr_addr_q;
    assign busy        = (state_q != IDLE);
    assign cpu_hold    = busy;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench: table of load cases, a write scoreboard, and reset-mid-load sequence.
module tb_imem_loader;

    localparam int BS = 4;
    localparam int AW = 12;
    localparam int MB = 56;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, cpu_hold, done, err;

    imem_loader_if #(.BYTE_SIZE(BS), .ADDR_WIDTH(AW)) bus ();

    imem_loader #(
        .BYTE_SIZE  (BS),
        .ADDR_WIDTH (AW),
        .MEM_BYTES  (MB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
        logic          last;
    } wr_t;

    typedef struct {
        int         n;
        logic [7:0] first;
        logic [7:0] step;
        bit         gap;
        bit         mid_start;
        bit         exp_err;
        int         exp_words;
    } vec_t;

    wr_t        exp_q[$];
    vec_t       vecs[9];
    logic [7:0] stream_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         wr_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: every write strobe is popped and compared against the model.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) check("cpu_hold_eq_busy", cpu_hold, busy);
        if (rst_n && bus.wr_en) begin
            wr_count++;
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", bus.wr_addr, e.addr);
                check("wr_data", bus.wr_data, e.data);
                check("wr_be",   bus.wr_be,   e.be);
                check("done_with_wr", done, e.last);
                check("busy_with_wr", busy, !e.last);
            end
        end
    end

    // Builds the byte stream and the expected write sequence for one case.
    task automatic build(input vec_t v);
        logic [31:0] data;
        logic [3:0]  be;
        logic [15:0] n16;
        n16 = 16'(v.n);
        stream_q.delete();
        exp_q.delete();
        stream_q.push_back(n16[7:0]);
        stream_q.push_back(n16[15:8]);
        if (v.n > 0 && v.n <= MB) begin
            for (int i = 0; i < v.n; i++) stream_q.push_back(v.first + v.step * 8'(i));
            for (int w = 0; w * BS < v.n; w++) begin
                data = '0;
                be   = '0;
                for (int r = 0; r < BS && (w * BS + r) < v.n; r++) begin
                    data[r*8 +: 8] = v.first + v.step * 8'(w * BS + r);
                    be[r]          = 1'b1;
                end
                exp_q.push_back('{AW'(w * BS), data, be, (w * BS + BS) >= v.n});
            end
        end
    endtask

    // Pulse start; called at posedge+1.
    task automatic start_pulse(input int idx);
        start = 1'b1;
        @(negedge clk);
        check($sformatf("c%0d_busy_before_start", idx), busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("c%0d_busy_after_start", idx), busy, 1);
    endtask

    // Drives stream_q; returns at posedge+1 after the last handshake.
    task automatic drive_stream(input int idx, input bit gap, input bit mid_start);
        int t;
        int nb;
        nb = stream_q.size();
        for (int i = 0; i < nb; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = stream_q[i];
            if (mid_start && i == 4) start = 1'b1;
            t = 0;
            @(negedge clk);
            while (!bus.s_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!bus.s_ready) begin
                check($sformatf("c%0d_ready_timeout", idx), bus.s_ready, 1);
                bus.s_valid = 1'b0;
                start       = 1'b0;
                return;
            end
            @(posedge clk); #1;
            bus.s_valid = 1'b0;
            start       = 1'b0;
            if (gap && i + 1 < nb) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic run_load(input vec_t v, input int idx);
        build(v);
        wr_count = 0;
        start_pulse(idx);
        drive_stream(idx, v.gap, v.mid_start);
        check($sformatf("c%0d_done", idx),    done, !v.exp_err);
        check($sformatf("c%0d_err", idx),     err,  v.exp_err);
        check($sformatf("c%0d_busy_end", idx), busy, 0);
        check($sformatf("c%0d_ready_end", idx), bus.s_ready, 0);
        @(negedge clk); #1;
        check($sformatf("c%0d_pending_writes", idx), exp_q.size(), 0);
        check($sformatf("c%0d_write_count", idx), wr_count, v.exp_words);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{8,   8'h11, 8'h11, 1'b0, 1'b0, 1'b0, 2};
        vecs[1] = '{5,   8'hAA, 8'h11, 1'b0, 1'b0, 1'b0, 2};
        vecs[2] = '{0,   8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0};
        vecs[3] = '{57,  8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{56,  8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 14};
        vecs[5] = '{8,   8'h11, 8'h11, 1'b1, 1'b1, 1'b0, 2};
        vecs[6] = '{1,   8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1};
        vecs[7] = '{7,   8'h80, 8'h03, 1'b1, 1'b0, 1'b0, 2};
        vecs[8] = '{256, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 0};

        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {bus.wr_en, busy, cpu_hold, done, err, bus.s_ready,
                                bus.wr_addr, bus.wr_data, bus.wr_be}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 9; k++) run_load(vecs[k], k);

        // Reset after three data bytes: partial word is dropped, then a clean reload.
        exp_q.delete();
        wr_count = 0;
        start_pulse(90);
        stream_q.delete();
        stream_q.push_back(8'h08);
        stream_q.push_back(8'h00);
        stream_q.push_back(8'h01);
        stream_q.push_back(8'h02);
        stream_q.push_back(8'h03);
        drive_stream(90, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("midload_reset_outputs", {bus.wr_en, busy, cpu_hold, done, err, bus.s_ready,
                                        bus.wr_addr, bus.wr_data, bus.wr_be}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midload_reset_no_write", wr_count, 0);
        check("midload_reset_done", done, 0);
        run_load(vecs[0], 91);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
